// File: rtl/uart_host_pkg.sv
// Shared state encoding and UART register map for uart_script_host.
package uart_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_GAP,
        ST_STAT_RD,
        ST_STAT_CHK,
        ST_DATA_RD,
        ST_DATA_CAP,
        ST_TX_WR
    } state_t;

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_STAT = 2'd2;

    localparam int STAT_RX_BIT = 0;
    localparam int STAT_TX_BIT = 1;

endpackage

// File: rtl/uart_host_script_ram.sv
// Script byte buffer: synchronous write port, asynchronous read port.
module uart_host_script_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_script_host.sv
// Polls a UART register block, sends a stored byte script and drains RX bytes to a stream.
// Optional build macro: UART_SCRIPT_HOST_FILTER_EN drops FILTER_CHAR bytes from the RX stream.
module uart_script_host
    import uart_host_pkg::*;
#(
    parameter int              DATA_W       = 8,
    parameter int              SCRIPT_DEPTH = 64,
    parameter int              START_DELAY  = 800000,
    parameter int              POLL_GAP     = 10,
    parameter logic [DATA_W-1:0] FILTER_CHAR = 8'h0A
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_we,
    input  logic [$clog2(SCRIPT_DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]               load_data,
    input  logic [$clog2(SCRIPT_DEPTH):0]   script_len,
    input  logic                            start,
    input  logic                            stop,
    output logic                            busy,
    output logic                            done,
    output logic                            rx_valid,
    output logic [DATA_W-1:0]               rx_data,
    input  logic                            rx_ready,
    output logic                            uart_wr,
    output logic                            uart_rd,
    output logic [1:0]                      uart_adr,
    output logic [DATA_W-1:0]               uart_din,
    input  logic [DATA_W-1:0]               uart_dout
);

    localparam int AW = $clog2(SCRIPT_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [LW-1:0] LEN_MAX    = LW'(SCRIPT_DEPTH);
    localparam logic [DW-1:0] DELAY_INIT = DW'(START_DELAY);
    localparam logic [GW-1:0] GAP_INIT   = GW'(POLL_GAP);

`ifdef UART_SCRIPT_HOST_FILTER_EN
    localparam logic FILTER_ON = 1'b1;
`else
    localparam logic FILTER_ON = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     delay_cnt_q, delay_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              uart_wr_q, uart_wr_d;
    logic              uart_rd_q, uart_rd_d;
    logic [1:0]        uart_adr_q, uart_adr_d;
    logic [DATA_W-1:0] uart_din_q, uart_din_d;

    logic [DATA_W-1:0] script_byte;
    logic [LW-1:0]     len_clamped;
    logic [LW-1:0]     idx_next;
    logic              delay_expired;
    logic              rx_keep;

    uart_host_script_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (SCRIPT_DEPTH),
        .ADDR_W (AW)
    ) u_script_ram (
        .clk   (clk),
        .we    (load_we && !busy_q),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (idx_q[AW-1:0]),
        .rdata (script_byte)
    );

    assign len_clamped   = (script_len > LEN_MAX) ? LEN_MAX : script_len;
    assign idx_next      = idx_q + LW'(1);
    assign delay_expired = (delay_cnt_q == '0);
    assign rx_keep       = !(FILTER_ON && (uart_dout == FILTER_CHAR));

    // The start delay runs in the background so RX polling is never held off by it.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        delay_cnt_d = delay_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = done_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;

        if (state_q != ST_IDLE && !delay_expired) begin
            delay_cnt_d = delay_cnt_q - DW'(1);
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = len_clamped;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    delay_cnt_d = DELAY_INIT;
                    gap_cnt_d   = GAP_INIT;
                    state_d     = (START_DELAY == 0) ? ST_GAP : ST_DELAY;
                end
            end
            ST_DELAY: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q <= GW'(1)) begin
                    state_d = ST_STAT_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            ST_STAT_RD: begin
                state_d = ST_STAT_CHK;
            end
            ST_STAT_CHK: begin
                gap_cnt_d = GAP_INIT;
                if (delay_expired && idx_q == len_q) begin
                    done_d = 1'b1;
                end
                if (uart_dout[STAT_RX_BIT] && !rx_valid_q) begin
                    state_d = ST_DATA_RD;
                end else if (!uart_dout[STAT_TX_BIT] && delay_expired && idx_q < len_q) begin
                    state_d = ST_TX_WR;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DATA_RD: begin
                state_d = ST_DATA_CAP;
            end
            ST_DATA_CAP: begin
                gap_cnt_d = GAP_INIT;
                state_d   = ST_GAP;
                if (rx_keep) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = uart_dout;
                end
            end
            ST_TX_WR: begin
                idx_d     = idx_next;
                gap_cnt_d = GAP_INIT;
                state_d   = ST_GAP;
                if (idx_next == len_q) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus strobes are decoded from the next state so they line up with the state that owns them.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        uart_wr_d  = (state_d == ST_TX_WR);
        uart_rd_d  = (state_d == ST_STAT_RD) || (state_d == ST_DATA_RD);
        uart_adr_d = (state_d == ST_STAT_RD) ? ADR_STAT : ADR_DATA;
        uart_din_d = (state_d == ST_TX_WR) ? script_byte : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            delay_cnt_q <= '0;
            gap_cnt_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            uart_wr_q   <= 1'b0;
            uart_rd_q   <= 1'b0;
            uart_adr_q  <= '0;
            uart_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            delay_cnt_q <= delay_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            uart_wr_q   <= uart_wr_d;
            uart_rd_q   <= uart_rd_d;
            uart_adr_q  <= uart_adr_d;
            uart_din_q  <= uart_din_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign uart_wr  = uart_wr_q;
    assign uart_rd  = uart_rd_q;
    assign uart_adr = uart_adr_q;
    assign uart_din = uart_din_q;

endmodule
